// File: rtl/fetch_unit_pkg.sv
// Shared codes for the fetch stage: the NOP word handed to decode, the fetch
// FSM encoding, and a saturating-increment helper for the optional counters.
package fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // DRAIN marks an outstanding request issued under an older epoch.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs sitting between instruction
// memory and the fetch output register. Flush empties it in one cycle.
module fetch_queue #(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_pc,
  input  logic [31:0]         push_inst,
  output logic [PC_WIDTH-1:0] head_pc,
  output logic [31:0]         head_inst,
  output logic [1:0]          count
);

  logic [PC_WIDTH-1:0] pc_mem   [2];
  logic [31:0]         inst_mem [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic                do_push;
  logic                do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count alone says which slots are live.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      pc_mem[wr_ptr]   <= push_pc;
      inst_mem[wr_ptr] <= push_inst;
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word-addressed PC, single outstanding imem request,
// 2-entry return queue, registered output to decode. Optional FETCH_PERF_EN
// adds saturating fetched/discarded/stall-cycle counters and their ports.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned          PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic [31:0]         inst,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_discarded,
  output logic [31:0]         perf_stall
`endif
);

  fetch_state_e        state;
  fetch_state_e        state_next;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic                accept;
  logic                pending;
  logic                resp_match;
  logic                bypass;
  logic                push;
  logic                pop;
  logic [1:0]          q_count;
  logic [PC_WIDTH-1:0] q_head_pc;
  logic [31:0]         q_head_inst;

  assign imem_addr = pc;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pending    = (state == WAIT);
    resp_match = imem_rvalid && (state == WAIT) && !redirect_valid;
    // Space is reserved for a pending response so a push never meets a full queue.
    imem_req   = !reset && !redirect_valid && ((state == IDLE) || imem_rvalid) &&
                 (({1'b0, q_count} + {2'b00, pending}) < 3'd2);
    accept     = imem_req && imem_ready;
    bypass     = resp_match && !stall && (q_count == 2'd0);
    push       = resp_match && !bypass;
    pop        = !redirect_valid && !stall && (q_count != 2'd0);

    case (state)
      IDLE: begin
        if (accept) state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid)   state_next = imem_rvalid ? IDLE : DRAIN;
        else if (imem_rvalid) state_next = accept ? WAIT : IDLE;
      end
      DRAIN: begin
        if (imem_rvalid) state_next = accept ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      inst       <= NOP;
      pc_out     <= '0;
      inst_valid <= 1'b0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      else if (accept)    pc <= pc + PC_WIDTH'(1);

      if (accept) req_pc <= pc;

      // Redirect overrides stall; an empty queue with no bypass yields a bubble.
      if (redirect_valid) begin
        inst       <= NOP;
        inst_valid <= 1'b0;
      end else if (!stall) begin
        if (q_count != 2'd0) begin
          inst       <= q_head_inst;
          pc_out     <= q_head_pc;
          inst_valid <= 1'b1;
        end else if (bypass) begin
          inst       <= imem_rdata;
          pc_out     <= req_pc;
          inst_valid <= 1'b1;
        end else begin
          inst       <= NOP;
          inst_valid <= 1'b0;
        end
      end
    end
  end

  fetch_queue #(.PC_WIDTH(PC_WIDTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_pc   (req_pc),
    .push_inst (imem_rdata),
    .head_pc   (q_head_pc),
    .head_inst (q_head_inst),
    .count     (q_count)
  );

`ifdef FETCH_PERF_EN
  logic resp_stale;

  assign resp_stale = imem_rvalid && ((state == DRAIN) || ((state == WAIT) && redirect_valid));

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched   <= '0;
      perf_discarded <= '0;
      perf_stall     <= '0;
    end else begin
      if (resp_match) perf_fetched   <= sat_inc(perf_fetched);
      if (resp_stale) perf_discarded <= sat_inc(perf_discarded);
      if (stall)      perf_stall     <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an in-bench instruction memory returns the
// request address as data after a configurable latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        inst_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
  logic [31:0] perf_stall;
`endif

  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst           (inst),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

  // One clock: sample the request before the edge, update the memory model after it.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      paddr = a;
      cnt   = lat;
    end
    if (pend) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = paddr;
        pend        = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    imem_ready     = 1'b1;
    imem_rvalid    = 1'b0;
    pend           = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req got=%b want=0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr got=%h want=00000000", imem_addr);
    end
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b0, 32'h0, NOP}) begin
      failures++;
      $display("FAIL reset_out got v=%b pc=%h inst=%h want v=0 pc=0 inst=%h",
               inst_valid, pc_out, inst, NOP);
    end
    reset = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    lat = 1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL stream_first_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({inst_valid, pc_out, inst} !== {1'b1, 32'(k), 32'(k)}) begin
        failures++;
        $display("FAIL stream[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, inst_valid, pc_out, inst, 32'(k), 32'(k));
      end
      if (k < 3) tick();
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({inst_valid, pc_out, inst} !== {1'b1, 32'h3, 32'h3}) begin
        failures++;
        $display("FAIL stall_frozen[%0d] got v=%b pc=%h inst=%h want v=1 pc=3 inst=3",
                 i, inst_valid, pc_out, inst);
      end
      checks++;
      if (imem_req !== 1'b0) begin
        failures++;
        $display("FAIL stall_req_drop[%0d] got=%b want=0", i, imem_req);
      end
    end
    stall = 1'b0;
    for (int k = 4; k < 8; k++) begin
      tick();
      checks++;
      if ({inst_valid, pc_out, inst} !== {1'b1, 32'(k), 32'(k)}) begin
        failures++;
        $display("FAIL stall_resume[%0d] got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                 k, inst_valid, pc_out, inst, 32'(k), 32'(k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 2;
    tick();
    tick();
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL redir_pre got v=%b pc=%h inst=%h want v=1 pc=0 inst=0",
               inst_valid, pc_out, inst);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_req got=%b want=0", imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({inst_valid, inst} !== {1'b0, NOP}) begin
      failures++;
      $display("FAIL redir_nop got v=%b inst=%h want v=0 inst=%h", inst_valid, inst, NOP);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      failures++;
      $display("FAIL redir_refetch got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_stale_dropped[%0d] got v=%b pc=%h want v=0", i, inst_valid, pc_out);
      end
    end
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h40, 32'h40}) begin
      failures++;
      $display("FAIL redir_new_path got v=%b pc=%h inst=%h want v=1 pc=40 inst=40",
               inst_valid, pc_out, inst);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    lat = 1;
    tick();
    tick();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rs_no_req got=%b want=0", imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({inst_valid, inst} !== {1'b0, NOP}) begin
      failures++;
      $display("FAIL rs_nop got v=%b inst=%h want v=0 inst=%h", inst_valid, inst, NOP);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      failures++;
      $display("FAIL rs_refetch got req=%b addr=%h want req=1 addr=40", imem_req, imem_addr);
    end
    tick();
    stall = 1'b0;
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h40, 32'h40}) begin
      failures++;
      $display("FAIL rs_new_path got v=%b pc=%h inst=%h want v=1 pc=40 inst=40",
               inst_valid, pc_out, inst);
    end
  endtask

  task automatic test_ready_low();
    do_reset();
    lat        = 1;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h0, 1'b0}) begin
        failures++;
        $display("FAIL ready_low[%0d] got req=%b addr=%h v=%b want req=1 addr=0 v=0",
                 i, imem_req, imem_addr, inst_valid);
      end
      tick();
    end
    imem_ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL ready_resume got v=%b pc=%h inst=%h want v=1 pc=0 inst=0",
               inst_valid, pc_out, inst);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat            = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL wrap_top got req=%b addr=%h want req=1 addr=ffffffff", imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL wrap_zero got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL wrap_out_top got v=%b pc=%h inst=%h want v=1 pc=ffffffff",
               inst_valid, pc_out, inst);
    end
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL wrap_out_zero got v=%b pc=%h inst=%h want v=1 pc=0 inst=0",
               inst_valid, pc_out, inst);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    lat = 2;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      failures++;
      $display("FAIL midreset_req got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_discard[%0d] got v=%b pc=%h want v=0", i, inst_valid, pc_out);
      end
    end
    tick();
    checks++;
    if ({inst_valid, pc_out, inst} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL midreset_refetch got v=%b pc=%h inst=%h want v=1 pc=0 inst=0",
               inst_valid, pc_out, inst);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_ready_low();
    test_wrap();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
